// File: rtl/pipeline_ir_sequencer.sv
// Instruction-register sequencer for the 5-stage pipeline: moves fetched words through
// OF/EX/MA/RW, stalls for one cycle on load-use hazards and flushes on taken branches.
module pipeline_ir_sequencer #(
   parameter int              IR_W   = 32,
   parameter logic [IR_W-1:0] NOP_IR = 32'h6800_0000,
   parameter int              CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             if_valid,
   input  logic [IR_W-1:0]  if_ir,
   input  logic             branch_taken,
   output logic             if_ready,
   output logic [IR_W-1:0]  of_ir,
   output logic [IR_W-1:0]  ex_ir,
   output logic [IR_W-1:0]  ma_ir,
   output logic [IR_W-1:0]  rw_ir,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [4:0] OP_ALU_MAX = 5'b01100;
   localparam logic [4:0] OP_NOT     = 5'b01000;
   localparam logic [4:0] OP_MOV     = 5'b01001;
   localparam logic [4:0] OP_NOP     = 5'b01101;
   localparam logic [4:0] OP_LD      = 5'b01110;
   localparam logic [4:0] OP_ST      = 5'b01111;
   localparam logic [4:0] OP_BEQ     = 5'b10000;
   localparam logic [4:0] OP_BGT     = 5'b10001;
   localparam logic [4:0] OP_B       = 5'b10010;
   localparam logic [4:0] OP_CALL    = 5'b10011;
   localparam logic [4:0] OP_RET     = 5'b10100;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [IR_W-1:0]  of_ir_q, of_ir_d;
   logic [IR_W-1:0]  ex_ir_q, ex_ir_d;
   logic [IR_W-1:0]  ma_ir_q, ma_ir_d;
   logic [IR_W-1:0]  rw_ir_q, rw_ir_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [4:0] of_op;
   logic [4:0] ex_op;
   logic [3:0] ld_rd;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       uses_rd;
   logic       src_hit;
   logic       stall_int;

   // Which registers the OF instruction reads, compared against the destination of a
   // load sitting in EX; store data counts because there is no MA-to-EX store bypass.
   always_comb begin
      of_op    = of_ir_q[31:27];
      ex_op    = ex_ir_q[31:27];
      ld_rd    = ex_ir_q[25:22];
      uses_rs1 = 1'b1;
      case (of_op)
         OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET, OP_MOV, OP_NOT: uses_rs1 = 1'b0;
         default: uses_rs1 = 1'b1;
      endcase
      uses_rs2  = !of_ir_q[26] && (of_op <= OP_ALU_MAX);
      uses_rd   = (of_op == OP_ST);
      src_hit   = (uses_rs1 && (of_ir_q[21:18] == ld_rd)) ||
                  (uses_rs2 && (of_ir_q[17:14] == ld_rd)) ||
                  (uses_rd  && (of_ir_q[25:22] == ld_rd));
      stall_int = (ex_op == OP_LD) && src_hit && !branch_taken;
   end

   // Flush outranks stall; a stall injects a bubble into EX while OF holds its word.
   always_comb begin
      rw_ir_d     = ma_ir_q;
      ma_ir_d     = ex_ir_q;
      ex_ir_d     = of_ir_q;
      of_ir_d     = if_valid ? if_ir : NOP_IR;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (branch_taken) begin
         ex_ir_d = NOP_IR;
         of_ir_d = NOP_IR;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (stall_int) begin
         ex_ir_d = NOP_IR;
         of_ir_d = of_ir_q;
         if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         of_ir_q     <= NOP_IR;
         ex_ir_q     <= NOP_IR;
         ma_ir_q     <= NOP_IR;
         rw_ir_q     <= NOP_IR;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         of_ir_q     <= of_ir_d;
         ex_ir_q     <= ex_ir_d;
         ma_ir_q     <= ma_ir_d;
         rw_ir_q     <= rw_ir_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign of_ir     = of_ir_q;
   assign ex_ir     = ex_ir_q;
   assign ma_ir     = ma_ir_q;
   assign rw_ir     = rw_ir_q;
   assign stall     = stall_int;
   assign flush     = branch_taken;
   assign if_ready  = !stall_int;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ir_sequencer.sv
// Self-checking bench for pipeline_ir_sequencer: directed vector table, randomized run
// against a register-set reference model, and counter saturation / async reset checks.
module tb_pipeline_ir_sequencer;

   localparam logic [31:0] NOP  = 32'h6800_0000;
   localparam logic [31:0] LD   = 32'h74C4_0004;
   localparam logic [31:0] ADD1 = 32'h014C_8000;
   localparam logic [31:0] ADD2 = 32'h0148_C000;
   localparam logic [31:0] ST   = 32'h7CD0_0000;
   localparam logic [31:0] ADDI = 32'h0544_C000;
   localparam logic [31:0] LD33 = 32'h74CC_0004;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_ir = '0;
   logic        branch_taken = 1'b0;
   logic        if_ready, stall, flush;
   logic [31:0] of_ir, ex_ir, ma_ir, rw_ir;
   logic [15:0] stall_cnt, flush_cnt;

   logic        if_valid_s = 1'b0;
   logic [31:0] if_ir_s = '0;
   logic        branch_taken_s = 1'b0;
   logic        if_ready_s, stall_s, flush_s;
   logic [31:0] of_ir_s, ex_ir_s, ma_ir_s, rw_ir_s;
   logic [3:0]  stall_cnt_s, flush_cnt_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_ir_sequencer dut (
      .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ir(if_ir),
      .branch_taken(branch_taken), .if_ready(if_ready), .of_ir(of_ir), .ex_ir(ex_ir),
      .ma_ir(ma_ir), .rw_ir(rw_ir), .stall(stall), .flush(flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ir_sequencer #(.CNT_W(4)) dut_small (
      .clk(clk), .reset_n(reset_n), .if_valid(if_valid_s), .if_ir(if_ir_s),
      .branch_taken(branch_taken_s), .if_ready(if_ready_s), .of_ir(of_ir_s), .ex_ir(ex_ir_s),
      .ma_ir(ma_ir_s), .rw_ir(rw_ir_s), .stall(stall_s), .flush(flush_s),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   // Reference model: the pipeline as a list of four words, oldest last.
   logic [31:0] pipe [4];
   int          m_sc, m_fc;

   function automatic logic [15:0] readsMask(input logic [31:0] ir);
      logic [15:0] m;
      logic [4:0]  op;
      m  = '0;
      op = ir[31:27];
      if (!(op inside {5'b01101, 5'b10010, 5'b10000, 5'b10001, 5'b10011, 5'b10100,
                       5'b01001, 5'b01000}))
         m[ir[21:18]] = 1'b1;
      if (!ir[26] && op <= 5'd12) m[ir[17:14]] = 1'b1;
      if (op == 5'b01111) m[ir[25:22]] = 1'b1;
      return m;
   endfunction

   function automatic logic modelStall(input logic br);
      logic [15:0] m;
      m = readsMask(pipe[0]);
      return (pipe[1][31:27] == 5'b01110) && m[pipe[1][25:22]] && !br;
   endfunction

   task automatic modelStep(input logic v, input logic [31:0] ir, input logic br);
      logic hz;
      hz = modelStall(br);
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      if (br) begin
         pipe[1] = NOP;
         pipe[0] = NOP;
         m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
      end else if (hz) begin
         pipe[1] = NOP;
         m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
      end else begin
         pipe[1] = pipe[0];
         pipe[0] = v ? ir : NOP;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic br);
      if_valid     = v;
      if_ir        = ir;
      branch_taken = br;
      #1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) pipe[i] = NOP;
      m_sc = 0;
      m_fc = 0;
   endtask

   typedef struct {
      logic        v;
      logic [31:0] ir;
      logic        br;
      logic        exp_stall;
      logic        exp_rdy;
      logic [31:0] exp_of;
      logic [31:0] exp_ex;
      logic [31:0] exp_rw;
      logic [15:0] exp_sc;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t vecs [20];

   function automatic logic [31:0] randIr();
      logic [31:0] ir;
      ir = $urandom;
      ir[31:27] = ($urandom_range(0, 2) == 0) ? 5'b01110 : 5'($urandom_range(0, 31));
      ir[25:22] = 4'($urandom_range(0, 3));
      ir[21:18] = 4'($urandom_range(0, 3));
      ir[17:14] = 4'($urandom_range(0, 3));
      return ir;
   endfunction

   initial begin
      vecs[0]  = '{1'b1, LD,   1'b0, 1'b0, 1'b1, LD,   NOP,  NOP,  16'd0, 16'd0};
      vecs[1]  = '{1'b1, ADD1, 1'b0, 1'b0, 1'b1, ADD1, LD,   NOP,  16'd0, 16'd0};
      vecs[2]  = '{1'b0, NOP,  1'b0, 1'b1, 1'b0, ADD1, NOP,  NOP,  16'd1, 16'd0};
      vecs[3]  = '{1'b0, NOP,  1'b0, 1'b0, 1'b1, NOP,  ADD1, LD,   16'd1, 16'd0};
      vecs[4]  = '{1'b0, NOP,  1'b0, 1'b0, 1'b1, NOP,  NOP,  NOP,  16'd1, 16'd0};
      vecs[5]  = '{1'b0, NOP,  1'b0, 1'b0, 1'b1, NOP,  NOP,  ADD1, 16'd1, 16'd0};
      vecs[6]  = '{1'b1, LD,   1'b0, 1'b0, 1'b1, LD,   NOP,  NOP,  16'd1, 16'd0};
      vecs[7]  = '{1'b1, ADD2, 1'b0, 1'b0, 1'b1, ADD2, LD,   NOP,  16'd1, 16'd0};
      vecs[8]  = '{1'b0, NOP,  1'b0, 1'b1, 1'b0, ADD2, NOP,  NOP,  16'd2, 16'd0};
      vecs[9]  = '{1'b1, LD,   1'b0, 1'b0, 1'b1, LD,   ADD2, LD,   16'd2, 16'd0};
      vecs[10] = '{1'b1, ST,   1'b0, 1'b0, 1'b1, ST,   LD,   NOP,  16'd2, 16'd0};
      vecs[11] = '{1'b0, NOP,  1'b0, 1'b1, 1'b0, ST,   NOP,  ADD2, 16'd3, 16'd0};
      vecs[12] = '{1'b1, LD,   1'b0, 1'b0, 1'b1, LD,   ST,   LD,   16'd3, 16'd0};
      vecs[13] = '{1'b1, ADDI, 1'b0, 1'b0, 1'b1, ADDI, LD,   NOP,  16'd3, 16'd0};
      vecs[14] = '{1'b0, NOP,  1'b0, 1'b0, 1'b1, NOP,  ADDI, ST,   16'd3, 16'd0};
      vecs[15] = '{1'b1, ADD1, 1'b1, 1'b0, 1'b1, NOP,  NOP,  LD,   16'd3, 16'd1};
      vecs[16] = '{1'b1, LD,   1'b0, 1'b0, 1'b1, LD,   NOP,  ADDI, 16'd3, 16'd1};
      vecs[17] = '{1'b1, ADD1, 1'b0, 1'b0, 1'b1, ADD1, LD,   NOP,  16'd3, 16'd1};
      vecs[18] = '{1'b1, ADD2, 1'b1, 1'b0, 1'b1, NOP,  NOP,  NOP,  16'd3, 16'd2};
      vecs[19] = '{1'b0, NOP,  1'b0, 1'b0, 1'b1, NOP,  NOP,  LD,   16'd3, 16'd2};

      // Reset behaviour: outputs held at NOP/0 while reset is low and after release.
      @(negedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_of", of_ir, NOP);
      checkOutput("rst_ex", ex_ir, NOP);
      checkOutput("rst_ma", ma_ir, NOP);
      checkOutput("rst_rw", rw_ir, NOP);
      checkOutput("rst_sc", 32'(stall_cnt), 32'd0);
      checkOutput("rst_fc", 32'(flush_cnt), 32'd0);
      resetDut();
      applyStimulus(1'b0, '0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("idle_of", of_ir, NOP);
      checkOutput("idle_rw", rw_ir, NOP);

      // Directed sequences: stalls on rs1/rs2/store data, no false stall, flushes.
      resetDut();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].v, vecs[i].ir, vecs[i].br);
         checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         checkOutput($sformatf("vec%0d_ready", i), 32'(if_ready), 32'(vecs[i].exp_rdy));
         checkOutput($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].br));
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_of", i), of_ir, vecs[i].exp_of);
         checkOutput($sformatf("vec%0d_ex", i), ex_ir, vecs[i].exp_ex);
         checkOutput($sformatf("vec%0d_rw", i), rw_ir, vecs[i].exp_rw);
         checkOutput($sformatf("vec%0d_sc", i), 32'(stall_cnt), 32'(vecs[i].exp_sc));
         checkOutput($sformatf("vec%0d_fc", i), 32'(flush_cnt), 32'(vecs[i].exp_fc));
      end

      // Randomized traffic against the reference model.
      resetDut();
      for (int c = 0; c < 1500; c++) begin
         logic        v, br, es;
         logic [31:0] ir;
         v  = ($urandom_range(0, 9) < 8);
         ir = randIr();
         br = ($urandom_range(0, 9) == 0);
         applyStimulus(v, ir, br);
         es = modelStall(br);
         checkOutput("rnd_stall", 32'(stall), 32'(es));
         checkOutput("rnd_ready", 32'(if_ready), 32'(!es));
         checkOutput("rnd_flush", 32'(flush), 32'(br));
         modelStep(v, ir, br);
         @(posedge clk);
         @(negedge clk);
         checkOutput("rnd_of", of_ir, pipe[0]);
         checkOutput("rnd_ex", ex_ir, pipe[1]);
         checkOutput("rnd_ma", ma_ir, pipe[2]);
         checkOutput("rnd_rw", rw_ir, pipe[3]);
         checkOutput("rnd_sc", 32'(stall_cnt), 32'(m_sc));
         checkOutput("rnd_fc", 32'(flush_cnt), 32'(m_fc));
      end

      // Stall counter saturation on the narrow instance: ld r3,[r3] back to back
      // stalls on every second edge starting with the third.
      resetDut();
      if_valid_s = 1'b1;
      if_ir_s    = LD33;
      repeat (9) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_s_4", 32'(stall_cnt_s), 32'd4);
      repeat (31) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_s_max", 32'(stall_cnt_s), 32'hF);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_s_hold", 32'(stall_cnt_s), 32'hF);
      checkOutput("sat_s_fc", 32'(flush_cnt_s), 32'd0);
      if_valid_s = 1'b0;

      // Flush counter saturation on the full-width instance.
      applyStimulus(1'b1, ADD1, 1'b1);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_fc_fffe", 32'(flush_cnt), 32'hFFFE);
      repeat (1) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_fc_ffff", 32'(flush_cnt), 32'hFFFF);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_fc_hold", 32'(flush_cnt), 32'hFFFF);
      checkOutput("sat_fc_sc", 32'(stall_cnt), 32'd0);

      // Asynchronous reset mid-run clears state without a clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_fc", 32'(flush_cnt), 32'd0);
      checkOutput("async_sc_s", 32'(stall_cnt_s), 32'd0);
      checkOutput("async_of", of_ir, NOP);
      checkOutput("async_of_s", of_ir_s, NOP);
      checkOutput("async_rw_s", rw_ir_s, NOP);
      applyStimulus(1'b0, '0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
